// File: rtl/ddr_dmaster_timing_adt_buf_if.sv
// ---------------------------------------------------------------------------
// ddr_dmaster_timing_adt_buf_if
//   Avalon-ST style beat interface around the DDR debug-master timing adapter.
//   Carries the upstream beat (no backpressure honoured) and the downstream
//   beat with ready-latency-0 handshake.
//
//   Signals
//     in_valid   upstream beat valid
//     in_data    upstream payload
//     in_ready   advisory "not full" indication back to the source
//     out_valid  downstream beat valid
//     out_data   downstream payload
//     out_ready  downstream ready (ready latency 0)
//
//   Modports
//     master  the side that sources in_* beats and sinks out_* beats
//     slave   the adapter itself
// ---------------------------------------------------------------------------
interface ddr_dmaster_timing_adt_buf_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/ddr_dmaster_timing_adt_buf.sv
// ---------------------------------------------------------------------------
// ddr_dmaster_timing_adt_buf
//   Timing adapter for the DDR debug-master byte path. The upstream source
//   cannot be stalled, so a FIFO_DEPTH-entry skid FIFO absorbs downstream
//   stalls. Beats arriving while the FIFO is full and not draining are
//   dropped; every drop sets a sticky overflow flag and bumps a saturating
//   counter so losses are never silent.
//
//   Parameters
//     DATA_WIDTH  payload width in bits
//     FIFO_DEPTH  skid entries (power of two, >= 2)
//     CNT_WIDTH   drop counter width (saturating)
//
//   Ports
//     clk           single rising-edge clock
//     reset_n       asynchronous active-low reset
//     bus           beat interface (slave modport)
//     fill_level    FIFO occupancy, 0..FIFO_DEPTH
//     overflow      sticky flag, set on any dropped beat
//     overflow_clr  synchronous clear of overflow and drop_cnt
//     drop_cnt      dropped-beat count, saturates at all-ones
//
//   Configuration macro
//     DDR_TADT_BYPASS_EN  when defined, an empty FIFO lets the input beat
//                         through combinationally (latency 0). When not
//                         defined every beat is registered (latency 1).
// ---------------------------------------------------------------------------
module ddr_dmaster_timing_adt_buf #(
  parameter  int DATA_WIDTH = 8,
  parameter  int FIFO_DEPTH = 4,
  parameter  int CNT_WIDTH  = 8,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int LVL_W      = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  ddr_dmaster_timing_adt_buf_if.slave bus,
  output logic [LVL_W-1:0]      fill_level,
  output logic                  overflow,
  input  logic                  overflow_clr,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wrPtr;
  logic [PTR_W-1:0]      r_rdPtr;
  logic [LVL_W-1:0]      r_fillLevel;
  logic                  r_overflow;
  logic [CNT_WIDTH-1:0]  r_dropCnt;

  logic w_empty;
  logic w_full;
  logic w_fifoPop;
  logic w_bypassTake;
  logic w_push;
  logic w_drop;

  assign w_empty = (r_fillLevel == '0);
  assign w_full  = (r_fillLevel == LVL_W'(FIFO_DEPTH));

  // Only a stored beat can be popped; a bypassed beat never touches the FIFO.
  assign w_fifoPop = !w_empty && bus.out_ready;

`ifdef DDR_TADT_BYPASS_EN
  // Empty FIFO: show the live input beat. If downstream takes it this cycle
  // it is consumed directly and must not also be queued.
  assign w_bypassTake  = w_empty && bus.in_valid && bus.out_ready;
  assign bus.out_valid = w_empty ? bus.in_valid : 1'b1;
  assign bus.out_data  = w_empty ? bus.in_data  : r_mem[r_rdPtr];
`else
  assign w_bypassTake  = 1'b0;
  assign bus.out_valid = !w_empty;
  assign bus.out_data  = r_mem[r_rdPtr];
`endif

  // A full FIFO still accepts a beat when its head leaves in the same cycle.
  assign w_push = bus.in_valid && (!w_full || w_fifoPop) && !w_bypassTake;
  assign w_drop = bus.in_valid && w_full && !w_fifoPop;

  // Advisory only; acceptance is decided by w_push, not by this signal.
  assign bus.in_ready = !w_full;

  assign fill_level = r_fillLevel;
  assign overflow   = r_overflow;
  assign drop_cnt   = r_dropCnt;

  // Storage array needs no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= bus.in_data;
    end
  end

  // Pointer and occupancy bookkeeping. Pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_fillLevel <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_fifoPop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_push, w_fifoPop})
        2'b10:   r_fillLevel <= r_fillLevel + LVL_W'(1);
        2'b01:   r_fillLevel <= r_fillLevel - LVL_W'(1);
        default: r_fillLevel <= r_fillLevel;
      endcase
    end
  end

  // Drop accounting. A drop in the same cycle as a clear wins, so the new
  // count starts at one rather than being lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
      r_dropCnt  <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (overflow_clr) begin
        r_dropCnt <= CNT_WIDTH'(1);
      end else if (r_dropCnt != '1) begin
        r_dropCnt <= r_dropCnt + CNT_WIDTH'(1);
      end
    end else if (overflow_clr) begin
      r_overflow <= 1'b0;
      r_dropCnt  <= '0;
    end
  end

endmodule

// File: tb/tb_ddr_dmaster_timing_adt_buf.sv
// ---------------------------------------------------------------------------
// tb_ddr_dmaster_timing_adt_buf
//   Directed and randomized stimulus for the DDR debug-master timing adapter.
//   A queue-based reference model decides which beats are accepted and
//   pushes them into a scoreboard; an independent monitor pops the
//   scoreboard whenever the adapter hands a beat downstream.
// ---------------------------------------------------------------------------
module tb_ddr_dmaster_timing_adt_buf;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 8;
  localparam int CMAX  = (1 << CW) - 1;

`ifdef DDR_TADT_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          overflow_clr;
  logic [2:0]    fill_level;
  logic          overflow;
  logic [CW-1:0] drop_cnt;

  ddr_dmaster_timing_adt_buf_if #(.DATA_WIDTH(DW)) bus();

  ddr_dmaster_timing_adt_buf #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .CNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .fill_level  (fill_level),
    .overflow    (overflow),
    .overflow_clr(overflow_clr),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int warnCount  = 0;

  logic [DW-1:0] sbQ[$];
  int modelFill = 0;
  bit modelOvf  = 1'b0;
  int modelCnt  = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [DW-1:0] d, input bit r, input bit c);
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    overflow_clr  = c;
  endtask

  // Reference model: checks status outputs mid-cycle, then decides from the
  // acceptance rules what the upcoming edge does to the buffered beats.
  initial begin
    bit mValid, fifoPop, byp, full, push, drop;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        sbQ.delete();
        modelFill = 0;
        modelOvf  = 1'b0;
        modelCnt  = 0;
      end else begin
        mValid = (modelFill > 0) || (BYPASS && bus.in_valid);
        checkOutput("fill_level", 32'(fill_level), modelFill);
        checkOutput("in_ready",   32'(bus.in_ready), 32'(modelFill < DEPTH));
        checkOutput("out_valid",  32'(bus.out_valid), 32'(mValid));
        checkOutput("overflow",   32'(overflow), 32'(modelOvf));
        checkOutput("drop_cnt",   32'(drop_cnt), modelCnt);
        if (bus.in_valid && !bus.in_ready && !bus.out_ready) begin
          warnCount++;
          if (warnCount <= 3)
            $display("[TB] warning: beat offered while full and stalled at %0t", $time);
        end
        fifoPop = (modelFill > 0) && bus.out_ready;
        byp     = BYPASS && (modelFill == 0) && bus.in_valid && bus.out_ready;
        full    = (modelFill == DEPTH);
        push    = bus.in_valid && (!full || fifoPop) && !byp;
        drop    = bus.in_valid && full && !fifoPop;
        if (push || byp) sbQ.push_back(bus.in_data);
        modelFill = modelFill + int'(push) - int'(fifoPop);
        if (drop) begin
          modelOvf = 1'b1;
          modelCnt = overflow_clr ? 1 : ((modelCnt < CMAX) ? modelCnt + 1 : CMAX);
        end else if (overflow_clr) begin
          modelOvf = 1'b0;
          modelCnt = 0;
        end
      end
    end
  end

  // Monitor: every beat handed downstream must be the oldest expected beat.
  initial begin
    logic [DW-1:0] expData;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && bus.out_valid && bus.out_ready) begin
        if (sbQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_beat: actual 0x%0h required none at %0t", bus.out_data, $time);
        end else begin
          expData = sbQ.pop_front();
          checkOutput("out_data", 32'(bus.out_data), 32'(expData));
        end
      end
    end
  end

  initial begin
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    overflow_clr  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_fill_level", 32'(fill_level), 0);
    checkOutput("rst_out_valid",  32'(bus.out_valid), 0);
    checkOutput("rst_overflow",   32'(overflow), 0);
    checkOutput("rst_drop_cnt",   32'(drop_cnt), 0);
    checkOutput("rst_in_ready",   32'(bus.in_ready), 1);
    @(negedge clk);
    #1;
    reset_n = 1'b1;

    $display("[TB] stream 0x01..0x10");
    for (int i = 1; i <= 16; i++) applyStimulus(1'b1, DW'(i), 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    $display("[TB] fill then drain");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, DW'(8'hA0 + i), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    repeat (6) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    $display("[TB] overflow, full with simultaneous pop, clear race");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, DW'(8'h90 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hB0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hB1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hC0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(8'hD0 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hE0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    $display("[TB] saturation");
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, DW'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    repeat (6) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, DW'(8'h70 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h7F, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid",  32'(bus.out_valid), 0);
    checkOutput("midrst_fill_level", 32'(fill_level), 0);
    checkOutput("midrst_overflow",   32'(overflow), 0);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h5B, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 99) < 70,
                    DW'($urandom),
                    $urandom_range(0, 99) < 50,
                    $urandom_range(0, 99) < 3);
    end

    repeat (10) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    #3;
    checkOutput("scoreboard_drained", sbQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
